// File: rtl/multi_chan_model_pkg.sv
// rtl/multi_chan_model_pkg.sv - shared types and model function for the multi-channel monitor
package multi_chan_model_pkg;
  localparam int EV_NCH = 4;
  localparam int EV_W   = 8;
  localparam int EV_CW  = (EV_NCH > 1) ? $clog2(EV_NCH) : 1;

  typedef enum logic [1:0] {MODE_ID, MODE_INV, MODE_INC} mode_e;

  typedef struct packed {
    logic [EV_CW-1:0] chan;
    logic [EV_W-1:0]  data;
  } ev_t;

  function automatic logic [EV_W-1:0] model_fn(input mode_e mode, input logic [EV_W-1:0] d);
    case (mode)
      MODE_INV: return ~d;
      MODE_INC: return d + 1'b1;
      default:  return d;
    endcase
  endfunction
endpackage

// File: rtl/model_event_fifo.sv
// rtl/model_event_fifo.sv - synchronous event FIFO with registered head and full/empty tracking
module model_event_fifo
  import multi_chan_model_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic wr_en,
  input  ev_t  wr_data,
  input  logic rd_en,
  output logic rd_valid,
  output ev_t  rd_data,
  output logic full
);
  localparam int AW = $clog2(DEPTH);

  ev_t           mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_rd;

  assign rd_valid = (count != '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign do_rd    = rd_en && rd_valid;
  // Gate the head so an empty queue presents all-zero outputs.
  assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end
endmodule

// File: rtl/multi_chan_model_monitor.sv
// rtl/multi_chan_model_monitor.sv - per-channel model pipeline, change detect, round-robin event queue
module multi_chan_model_monitor
  import multi_chan_model_pkg::*;
#(
  parameter int NCH   = EV_NCH,
  parameter int W     = EV_W,
  parameter int LAT   = 2,
  parameter int MODE  = 0,
  parameter int DEPTH = 8,
  parameter int CNTW  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NCH-1:0]      in_valid,
  input  logic [NCH*W-1:0]    in_data,
  output logic [NCH-1:0]      out_valid,
  output logic [NCH*W-1:0]    out_data,
  output logic                ev_valid,
  input  logic                ev_ready,
  output logic [EV_CW-1:0]    ev_chan,
  output logic [W-1:0]        ev_data,
  output logic                ev_ovf,
  input  logic                clr_cnt,
  output logic [NCH*CNTW-1:0] chg_cnt
);
  logic [NCH-1:0]   pend, grant, overwrite;
  logic [W-1:0]     pval [NCH];
  logic [EV_CW-1:0] rr_last, gsel;
  logic             fifo_full, pop, push_ok;
  ev_t              head, push_ev;

  assign pop = ev_valid && ev_ready;

  // Search starts one past the last granted channel.
  always_comb begin
    push_ok = !fifo_full || pop;
    grant   = '0;
    gsel    = '0;
    for (int i = 0; i < NCH; i++) begin
      automatic int k = (int'(rr_last) + 1 + i) % NCH;
      if (push_ok && grant == '0 && pend[k]) begin
        grant[k] = 1'b1;
        gsel     = EV_CW'(k);
      end
    end
  end

  always_comb begin
    push_ev.chan = gsel;
    push_ev.data = pval[gsel];
  end

  model_event_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (|grant),
    .wr_data  (push_ev),
    .rd_en    (pop),
    .rd_valid (ev_valid),
    .rd_data  (head),
    .full     (fifo_full)
  );

  assign ev_chan = head.chan;
  assign ev_data = head.data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last <= EV_CW'(NCH - 1);
      ev_ovf  <= 1'b0;
    end else begin
      if (|grant) rr_last <= gsel;
      if (clr_cnt)         ev_ovf <= 1'b0;
      else if (|overwrite) ev_ovf <= 1'b1;
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [W-1:0]    mdl, exit_d, held, pv;
    logic            exit_v, seen, ov, pd, chg;
    logic [CNTW-1:0] cnt;

    always_comb mdl = model_fn(mode_e'(MODE), in_data[c*W +: W]);

    // The final stage is the held output register, so LAT-1 stages precede it.
    if (LAT == 1) begin : g_direct
      assign exit_v = in_valid[c];
      assign exit_d = mdl;
    end else begin : g_pipe
      logic [LAT-2:0] sv;
      logic [W-1:0]   sd [LAT-1];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sv <= '0;
          for (int k = 0; k < LAT-1; k++) sd[k] <= '0;
        end else begin
          sv[0] <= in_valid[c];
          sd[0] <= mdl;
          for (int k = 1; k < LAT-1; k++) begin
            sv[k] <= sv[k-1];
            sd[k] <= sd[k-1];
          end
        end
      end
      assign exit_v = sv[LAT-2];
      assign exit_d = sd[LAT-2];
    end

    assign chg          = exit_v && (!seen || exit_d != held);
    assign overwrite[c] = chg && pd && !grant[c];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ov   <= 1'b0;
        held <= '0;
        seen <= 1'b0;
        pd   <= 1'b0;
        pv   <= '0;
        cnt  <= '0;
      end else begin
        ov <= exit_v;
        if (exit_v) begin
          held <= exit_d;
          seen <= 1'b1;
        end
        // A push this cycle reads the old pv, so a new change simply stays pending.
        if (chg) begin
          pd <= 1'b1;
          pv <= exit_d;
        end else if (grant[c]) begin
          pd <= 1'b0;
        end
        if (clr_cnt)               cnt <= '0;
        else if (chg && cnt != '1) cnt <= cnt + 1'b1;
      end
    end

    assign out_valid[c]             = ov;
    assign out_data[c*W +: W]       = held;
    assign pend[c]                  = pd;
    assign pval[c]                  = pv;
    assign chg_cnt[c*CNTW +: CNTW]  = cnt;
  end
endmodule

// File: tb/tb_multi_chan_model_monitor.sv
// tb/tb_multi_chan_model_monitor.sv - bench for multi_chan_model_monitor (MODE=1, LAT=2, DEPTH=8, CNTW=2)
module tb_multi_chan_model_monitor;
  localparam int NCH = 4, W = 8, LAT = 2, DEPTH = 8, CNTW = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NCH-1:0]    in_valid;
  logic [NCH*W-1:0]  in_data;
  logic [NCH-1:0]    out_valid;
  logic [NCH*W-1:0]  out_data;
  logic              ev_valid, ev_ready, ev_ovf, clr_cnt;
  logic [1:0]        ev_chan;
  logic [W-1:0]      ev_data;
  logic [NCH*CNTW-1:0] chg_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  multi_chan_model_monitor #(
    .NCH(NCH), .W(W), .LAT(LAT), .MODE(1), .DEPTH(DEPTH), .CNTW(CNTW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .ev_valid(ev_valid),
    .ev_ready(ev_ready), .ev_chan(ev_chan), .ev_data(ev_data), .ev_ovf(ev_ovf),
    .clr_cnt(clr_cnt), .chg_cnt(chg_cnt)
  );

  // Reference model: queues for the pipeline and event FIFO, arrays for per-channel state.
  typedef struct packed { logic [3:0] v; logic [31:0] d; } stg_t;
  typedef struct packed { logic [1:0] ch; logic [7:0] d; } mev_t;
  stg_t       pipe[$];
  mev_t       mfifo[$];
  stg_t       ex;
  mev_t       tmp;
  logic [3:0] m_ov;
  logic [7:0] m_held[4], m_pval[4], md;
  bit         m_seen[4], m_pend[4], m_ovf, mpop;
  int         m_cnt[4], last_g, g;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe.delete();
      mfifo.delete();
      m_ov = '0; m_ovf = 0; last_g = NCH - 1;
      for (int c = 0; c < NCH; c++) begin
        m_held[c] = '0; m_pval[c] = '0; m_seen[c] = 0; m_pend[c] = 0; m_cnt[c] = 0;
      end
    end else begin
      ex.v = in_valid; ex.d = in_data;
      pipe.push_back(ex);
      ex = '0;
      if (pipe.size() == LAT) ex = pipe.pop_front();
      mpop = (mfifo.size() != 0) && ev_ready;
      g = -1;
      if (mfifo.size() < DEPTH || mpop)
        for (int i = 1; i <= NCH; i++)
          if (g < 0 && m_pend[(last_g + i) % NCH]) g = (last_g + i) % NCH;
      if (mpop) tmp = mfifo.pop_front();
      if (g >= 0) begin
        tmp.ch = 2'(g); tmp.d = m_pval[g];
        mfifo.push_back(tmp);
        last_g = g;
      end
      m_ov = ex.v;
      for (int c = 0; c < NCH; c++) begin
        md = ~ex.d[c*8 +: 8];
        if (ex.v[c] && (!m_seen[c] || md != m_held[c])) begin
          if (m_pend[c] && g != c) m_ovf = 1;
          m_pend[c] = 1; m_pval[c] = md;
          if (m_cnt[c] < 3) m_cnt[c]++;
        end else if (g == c) begin
          m_pend[c] = 0;
        end
        if (ex.v[c]) begin m_held[c] = md; m_seen[c] = 1; end
      end
      if (clr_cnt) begin
        m_ovf = 0;
        for (int c = 0; c < NCH; c++) m_cnt[c] = 0;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [31:0] eod;
    logic [7:0]  ecnt;
    for (int c = 0; c < NCH; c++) begin
      eod[c*8 +: 8] = m_held[c];
      ecnt[c*2 +: 2] = 2'(m_cnt[c]);
    end
    chk("m_out_valid", 64'(out_valid), 64'(m_ov));
    chk("m_out_data",  64'(out_data), 64'(eod));
    chk("m_ev_valid",  64'(ev_valid), 64'(mfifo.size() != 0));
    chk("m_ev_chan",   64'(ev_chan), 64'((mfifo.size() != 0) ? mfifo[0].ch : 2'd0));
    chk("m_ev_data",   64'(ev_data), 64'((mfifo.size() != 0) ? mfifo[0].d : 8'd0));
    chk("m_ev_ovf",    64'(ev_ovf), 64'(m_ovf));
    chk("m_chg_cnt",   64'(chg_cnt), 64'(ecnt));
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({nm, "_out_data"},  64'(out_data), 64'd0);
    chk({nm, "_ev_valid"},  64'(ev_valid), 64'd0);
    chk({nm, "_ev_chan"},   64'(ev_chan), 64'd0);
    chk({nm, "_ev_data"},   64'(ev_data), 64'd0);
    chk({nm, "_ev_ovf"},    64'(ev_ovf), 64'd0);
    chk({nm, "_chg_cnt"},   64'(chg_cnt), 64'd0);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  task automatic do_reset(input string nm);
    #2 rst_n = 1'b0;
    #1 check_zero(nm);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [3:0]  iv;
    logic [31:0] id;
    logic [3:0]  e_ov;
    logic [31:0] e_od;
    logic        e_evv;
    logic [1:0]  e_ch;
    logic [7:0]  e_ed;
    logic [7:0]  e_cnt;
  } vec_t;
  vec_t tbl[12];

  int n_pop;
  logic [7:0] last_d;

  initial begin
    // Latency/mode on ch0, then no-change and change on ch1; expected state after each edge.
    tbl[0]  = '{4'h1, 32'h0000003C, 4'h0, 32'h00000000, 1'b0, 2'd0, 8'h00, 8'h00};
    tbl[1]  = '{4'h0, 32'h00000000, 4'h1, 32'h000000C3, 1'b0, 2'd0, 8'h00, 8'h01};
    tbl[2]  = '{4'h0, 32'h00000000, 4'h0, 32'h000000C3, 1'b1, 2'd0, 8'hC3, 8'h01};
    tbl[3]  = '{4'h0, 32'h00000000, 4'h0, 32'h000000C3, 1'b0, 2'd0, 8'h00, 8'h01};
    tbl[4]  = '{4'h2, 32'h00000500, 4'h0, 32'h000000C3, 1'b0, 2'd0, 8'h00, 8'h01};
    tbl[5]  = '{4'h2, 32'h00000500, 4'h2, 32'h0000FAC3, 1'b0, 2'd0, 8'h00, 8'h05};
    tbl[6]  = '{4'h0, 32'h00000000, 4'h2, 32'h0000FAC3, 1'b1, 2'd1, 8'hFA, 8'h05};
    tbl[7]  = '{4'h0, 32'h00000000, 4'h0, 32'h0000FAC3, 1'b0, 2'd0, 8'h00, 8'h05};
    tbl[8]  = '{4'h2, 32'h00000600, 4'h0, 32'h0000FAC3, 1'b0, 2'd0, 8'h00, 8'h05};
    tbl[9]  = '{4'h0, 32'h00000000, 4'h2, 32'h0000F9C3, 1'b0, 2'd0, 8'h00, 8'h09};
    tbl[10] = '{4'h0, 32'h00000000, 4'h0, 32'h0000F9C3, 1'b1, 2'd1, 8'hF9, 8'h09};
    tbl[11] = '{4'h0, 32'h00000000, 4'h0, 32'h0000F9C3, 1'b0, 2'd0, 8'h00, 8'h09};

    rst_n = 1'b0; in_valid = '0; in_data = '0; ev_ready = 1'b1; clr_cnt = 1'b0;
    @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      in_valid = tbl[i].iv; in_data = tbl[i].id;
      step();
      chk($sformatf("tbl%0d_out_valid", i), 64'(out_valid), 64'(tbl[i].e_ov));
      chk($sformatf("tbl%0d_out_data", i),  64'(out_data), 64'(tbl[i].e_od));
      chk($sformatf("tbl%0d_ev_valid", i),  64'(ev_valid), 64'(tbl[i].e_evv));
      chk($sformatf("tbl%0d_ev_chan", i),   64'(ev_chan), 64'(tbl[i].e_ch));
      chk($sformatf("tbl%0d_ev_data", i),   64'(ev_data), 64'(tbl[i].e_ed));
      chk($sformatf("tbl%0d_chg_cnt", i),   64'(chg_cnt), 64'(tbl[i].e_cnt));
    end

    // Arbitration from a fresh reset, then a second round resuming at ch0.
    do_reset("arb_reset");
    for (int r = 0; r < 2; r++) begin
      in_valid = 4'hF;
      for (int c = 0; c < NCH; c++) in_data[c*8 +: 8] = 8'(8'h10 * (r + 1) + c);
      step();
      in_valid = '0;
      step(); step();
      for (int c = 0; c < NCH; c++) begin
        chk($sformatf("arb_r%0d_valid%0d", r, c), 64'(ev_valid), 64'd1);
        chk($sformatf("arb_r%0d_chan%0d", r, c), 64'(ev_chan), 64'(c));
        step();
      end
      step();
    end

    // Full FIFO with one pending and one overwrite on ch2.
    ev_ready = 1'b0; in_valid = 4'h4;
    for (int k = 1; k <= 10; k++) begin
      in_data = 32'(k) << 16;
      step();
    end
    in_valid = '0;
    step(); step();
    chk("full_ovf", 64'(ev_ovf), 64'd1);
    ev_ready = 1'b1; n_pop = 0; last_d = '0;
    for (int i = 0; i < 14; i++) begin
      if (ev_valid) begin n_pop++; last_d = ev_data; end
      step();
    end
    chk("full_pop_count", 64'(n_pop), 64'd9);
    chk("full_last_data", 64'(last_d), 64'hF5);

    // Counter saturation, then clear coinciding with a change.
    clr_cnt = 1'b1; step(); clr_cnt = 1'b0;
    in_valid = 4'h8;
    for (int k = 1; k <= 5; k++) begin
      in_data = 32'(8'h40 + k) << 24;
      step();
    end
    in_valid = '0;
    step(); step(); step();
    chk("sat_cnt3", 64'(chg_cnt[7:6]), 64'd3);
    in_valid = 4'h8; in_data = 32'h50 << 24;
    step();
    in_valid = '0; clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    chk("clr_cnt3", 64'(chg_cnt[7:6]), 64'd0);
    chk("clr_ovf", 64'(ev_ovf), 64'd0);

    // Randomized traffic with a mid-stream reset.
    for (int i = 0; i < 400; i++) begin
      in_valid = 4'($urandom);
      for (int c = 0; c < NCH; c++) in_data[c*8 +: 8] = 8'($urandom_range(0, 3));
      ev_ready = ($urandom_range(0, 1) == 0);
      clr_cnt = ($urandom_range(0, 31) == 0);
      if (i == 200) begin
        do_reset("mid_reset");
        in_valid = '0; ev_ready = 1'b0; clr_cnt = 1'b0;
        for (int j = 0; j < 6; j++) begin
          step();
          chk("post_reset_ev", 64'(ev_valid), 64'd0);
          chk("post_reset_ov", 64'(out_valid), 64'd0);
        end
      end else begin
        step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
